move_controller: RTL

Sequences every move of a Connect4 game. Accepts a column-drop request from the input logic, places the current player's token in the lowest free row, scans the four lines through the new token for four-in-a-row, and reports the result. The 2-bit `game_status` and `player_turn` outputs drive the game FSM's `in_game_status` and `player_turn` inputs directly.

---
 rtl/connect4_pkg.sv | 44 ++++
 rtl/connect4_board.sv | 51 +++++
 rtl/move_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect4 constants, encodings and direction table
package connect4_pkg;

    localparam int COLS  = 7;
    localparam int ROWS  = 6;
    localparam int CELLS = COLS * ROWS;

    localparam logic [2:0] NCOLS = 3'(COLS);
    localparam logic [2:0] NROWS = 3'(ROWS);
    localparam logic [5:0] MAX_MOVES = 6'(CELLS);

    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] P1_CELL = 2'b01;
    localparam logic [1:0] P2_CELL = 2'b10;

    localparam logic [1:0] NEXT_TURN = 2'b00;
    localparam logic [1:0] P1_WIN    = 2'b01;
    localparam logic [1:0] P2_WIN    = 2'b10;
    localparam logic [1:0] TIE_GAME  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLACE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } ctrl_state_e;

    // Scan directions in order: horizontal, vertical, rising diagonal, falling diagonal
    function automatic logic signed [3:0] dir_dx(input logic [1:0] dir);
        case (dir)
            2'd1:    return 4'sd0;
            default: return 4'sd1;
        endcase
    endfunction

    function automatic logic signed [3:0] dir_dy(input logic [1:0] dir);
        case (dir)
            2'd0:    return 4'sd0;
            2'd3:    return -4'sd1;
            default: return 4'sd1;
        endcase
    endfunction

endpackage

// File: rtl/connect4_board.sv
// rtl/connect4_board.sv - board cell storage, column heights, scanner and display read ports
module connect4_board
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_col_i,
    input  logic [2:0] wr_row_i,
    input  logic [1:0] wr_cell_i,
    input  logic [2:0] hgt_col_i,
    output logic [2:0] hgt_o,
    input  logic [2:0] sc_col_i,
    input  logic [2:0] sc_row_i,
    output logic [1:0] sc_cell_o,
    input  logic [2:0] rd_col_i,
    input  logic [2:0] rd_row_i,
    output logic [1:0] rd_cell_o
);

    logic [1:0] cells_q   [CELLS];
    logic [2:0] heights_q [COLS];

    logic [5:0] wr_idx;
    logic [5:0] sc_idx;
    logic [5:0] rd_idx;

    // Cells are stored row-major: index = row * COLS + col
    assign wr_idx = 6'(wr_row_i) * 6'(COLS) + 6'(wr_col_i);
    assign sc_idx = 6'(sc_row_i) * 6'(COLS) + 6'(sc_col_i);
    assign rd_idx = 6'(rd_row_i) * 6'(COLS) + 6'(rd_col_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) cells_q[i] <= EMPTY;
            for (int c = 0; c < COLS; c++) heights_q[c] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < CELLS; i++) cells_q[i] <= EMPTY;
            for (int c = 0; c < COLS; c++) heights_q[c] <= '0;
        end else if (wr_en_i && (wr_col_i < NCOLS) && (wr_row_i < NROWS)) begin
            cells_q[wr_idx]     <= wr_cell_i;
            heights_q[wr_col_i] <= heights_q[wr_col_i] + 3'd1;
        end
    end

    assign hgt_o     = (hgt_col_i < NCOLS) ? heights_q[hgt_col_i] : 3'd0;
    assign sc_cell_o = ((sc_col_i < NCOLS) && (sc_row_i < NROWS)) ? cells_q[sc_idx] : EMPTY;
    assign rd_cell_o = ((rd_col_i < NCOLS) && (rd_row_i < NROWS)) ? cells_q[rd_idx] : EMPTY;

endmodule

// File: rtl/move_controller.sv
// rtl/move_controller.sv - Connect4 move sequencer: drop, fixed-length win scan, result report
module move_controller
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       drop_req,
    input  logic [2:0] drop_col,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic [1:0] game_status,
    output logic       player_turn,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell
);

    ctrl_state_e state_q, state_d;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [1:0] token_q, token_d;
    logic [5:0] moves_q, moves_d;
    logic [1:0] dir_q, dir_d;
    logic       side_q, side_d;
    logic [1:0] step_q, step_d;
    logic [2:0] run_q, run_d;
    logic       stop_q, stop_d;
    logic       win_q, win_d;
    logic       over_q, over_d;
    logic [1:0] status_q, status_d;
    logic       turn_q, turn_d;
    logic       illegal_q, illegal_d;

    logic [2:0] req_height;
    logic       wr_en;
    logic [2:0] sc_col;
    logic [2:0] sc_row;
    logic [1:0] sc_cell;
    logic signed [3:0] dx, dy, off, nx, ny;
    logic       nb_valid;
    logic       nb_match;
    logic [2:0] run_next;
    logic       dir_win;
    logic       reject;

    connect4_board u_board (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (new_game),
        .wr_en_i   (wr_en),
        .wr_col_i  (col_q),
        .wr_row_i  (row_q),
        .wr_cell_i (token_q),
        .hgt_col_i (drop_col),
        .hgt_o     (req_height),
        .sc_col_i  (sc_col),
        .sc_row_i  (sc_row),
        .sc_cell_o (sc_cell),
        .rd_col_i  (rd_col),
        .rd_row_i  (rd_row),
        .rd_cell_o (rd_cell)
    );

    // Neighbour at step*(dx,dy), mirrored on the negative side; 4-bit wrap lands negative
    always_comb begin
        dx       = dir_dx(dir_q);
        dy       = dir_dy(dir_q);
        off      = side_q ? -$signed({2'b00, step_q}) : $signed({2'b00, step_q});
        nx       = $signed({1'b0, col_q}) + dx * off;
        ny       = $signed({1'b0, row_q}) + dy * off;
        nb_valid = !nx[3] && (nx[2:0] < NCOLS) && !ny[3] && (ny[2:0] < NROWS);
        sc_col   = nx[2:0];
        sc_row   = ny[2:0];
        nb_match = nb_valid && (sc_cell == token_q);
        run_next = (!stop_q && nb_match) ? run_q + 3'd1 : run_q;
        dir_win  = side_q && (step_q == 2'd3) && (run_next >= 3'd3);
        reject   = (drop_col >= NCOLS) || (req_height == NROWS) || over_q;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        token_d   = token_q;
        moves_d   = moves_q;
        dir_d     = dir_q;
        side_d    = side_q;
        step_d    = step_q;
        run_d     = run_q;
        stop_d    = stop_q;
        win_d     = win_q;
        over_d    = over_q;
        status_d  = status_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        wr_en     = 1'b0;
        if (new_game) begin
            state_d  = ST_IDLE;
            col_d    = '0;
            row_d    = '0;
            token_d  = EMPTY;
            moves_d  = '0;
            dir_d    = '0;
            side_d   = 1'b0;
            step_d   = 2'd1;
            run_d    = '0;
            stop_d   = 1'b0;
            win_d    = 1'b0;
            over_d   = 1'b0;
            status_d = NEXT_TURN;
            turn_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (drop_req) begin
                        if (reject) begin
                            illegal_d = 1'b1;
                        end else begin
                            col_d   = drop_col;
                            row_d   = req_height;
                            token_d = {turn_q, ~turn_q};
                            state_d = ST_PLACE;
                        end
                    end
                end
                ST_PLACE: begin
                    wr_en   = 1'b1;
                    moves_d = moves_q + 6'd1;
                    run_d   = '0;
                    stop_d  = 1'b0;
                    win_d   = 1'b0;
                    dir_d   = '0;
                    side_d  = 1'b0;
                    step_d  = 2'd1;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    run_d = run_next;
                    if (!stop_q && !nb_match) stop_d = 1'b1;
                    if (step_q == 2'd3) begin
                        step_d = 2'd1;
                        stop_d = 1'b0;
                        side_d = ~side_q;
                        if (side_q) begin
                            run_d = '0;
                            dir_d = dir_q + 2'd1;
                            if (dir_win) win_d = 1'b1;
                            if (dir_q == 2'd3) begin
                                state_d = ST_REPORT;
                                if (win_q || dir_win) begin
                                    status_d = token_q;
                                    over_d   = 1'b1;
                                end else if (moves_q == MAX_MOVES) begin
                                    status_d = TIE_GAME;
                                    over_d   = 1'b1;
                                end else begin
                                    status_d = NEXT_TURN;
                                    turn_d   = ~turn_q;
                                end
                            end
                        end
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            token_q   <= EMPTY;
            moves_q   <= '0;
            dir_q     <= '0;
            side_q    <= 1'b0;
            step_q    <= 2'd1;
            run_q     <= '0;
            stop_q    <= 1'b0;
            win_q     <= 1'b0;
            over_q    <= 1'b0;
            status_q  <= NEXT_TURN;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            token_q   <= token_d;
            moves_q   <= moves_d;
            dir_q     <= dir_d;
            side_q    <= side_d;
            step_q    <= step_d;
            run_q     <= run_d;
            stop_q    <= stop_d;
            win_q     <= win_d;
            over_q    <= over_d;
            status_q  <= status_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_REPORT);
    assign illegal     = illegal_q;
    assign game_status = status_q;
    assign player_turn = turn_q;

endmodule
